// File: rtl/wb_queue.sv
// Writeback collector: round-robin arbitration of three result channels into
// a small in-order FIFO that drains one entry per cycle onto the register file port.
module wb_queue #(
    parameter int W_RD  = 4,
    parameter int W_OPR = 32,
    parameter int DEPTH = 4,
    parameter int W_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       valid_i,
    output logic [2:0]       ready_o,
    input  logic [W_RD-1:0]  rd0_i,
    input  logic [W_RD-1:0]  rd1_i,
    input  logic [W_RD-1:0]  rd2_i,
    input  logic [W_OPR-1:0] data0_i,
    input  logic [W_OPR-1:0] data1_i,
    input  logic [W_OPR-1:0] data2_i,
    input  logic             wb_hold_i,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic [W_OPR-1:0] result_o,
    output logic [W_CNT-1:0] qcount_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = W_RD + W_OPR;
    localparam logic [W_CNT-1:0] FULL = W_CNT'(DEPTH);

    // Candidate order starts one past the last granted channel.
    function automatic logic [2:0] rr_grant(input logic [1:0] last, input logic [2:0] vld);
        logic [2:0] g;
        g = 3'b000;
        case (last)
            2'd0: begin
                if (vld[1])      g = 3'b010;
                else if (vld[2]) g = 3'b100;
                else if (vld[0]) g = 3'b001;
            end
            2'd1: begin
                if (vld[2])      g = 3'b100;
                else if (vld[0]) g = 3'b001;
                else if (vld[1]) g = 3'b010;
            end
            default: begin
                if (vld[0])      g = 3'b001;
                else if (vld[1]) g = 3'b010;
                else if (vld[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [W_CNT-1:0] count_q, count_d;
    logic [1:0]       last_q, last_d;
    logic             wb_q, wb_d;
    logic [W_RD-1:0]  wb_r_q, wb_r_d;
    logic [W_OPR-1:0] result_q, result_d;

    logic [2:0]       grant;
    logic [2:0]       ready;
    logic             pop, space, push;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head;

    always_comb begin
        grant      = rr_grant(last_q, valid_i);
        pop        = ~wb_hold_i & (count_q != '0);
        space      = (count_q < FULL) | pop;
        ready      = reset ? 3'b000 : (grant & {3{space}});
        push       = |(valid_i & ready);
        head       = mem_q[rptr_q];
        push_entry = '0;
        last_d     = last_q;
        if (grant[0])      push_entry = {rd0_i, data0_i};
        else if (grant[1]) push_entry = {rd1_i, data1_i};
        else if (grant[2]) push_entry = {rd2_i, data2_i};
        if (push) begin
            if (grant[0])      last_d = 2'd0;
            else if (grant[1]) last_d = 2'd1;
            else               last_d = 2'd2;
        end

        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Result registers hold their last value whenever nothing drains.
        wb_d     = pop;
        wb_r_d   = pop ? head[EW-1:W_OPR] : wb_r_q;
        result_d = pop ? head[W_OPR-1:0] : result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            last_q   <= 2'd2;
            wb_q     <= 1'b0;
            wb_r_q   <= '0;
            result_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            wb_q     <= wb_d;
            wb_r_q   <= wb_r_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_entry;
    end

    assign ready_o  = ready;
    assign wb_o     = wb_q;
    assign wb_r_o   = wb_r_q;
    assign result_o = result_q;
    assign qcount_o = count_q;

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: arbitration order, fill/backpressure, full
// push+pop, reset flush and output hold on idle.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  valid_i;
    logic [2:0]  ready_o;
    logic [3:0]  rd0_i, rd1_i, rd2_i;
    logic [31:0] data0_i, data1_i, data2_i;
    logic        wb_hold_i;
    logic        wb_o;
    logic [3:0]  wb_r_o;
    logic [31:0] result_o;
    logic [2:0]  qcount_o;

    int checks = 0;
    int failures = 0;

    wb_queue #(.W_RD(4), .W_OPR(32), .DEPTH(4), .W_CNT(3)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .rd0_i(rd0_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
        .wb_hold_i(wb_hold_i), .wb_o(wb_o), .wb_r_o(wb_r_o),
        .result_o(result_o), .qcount_o(qcount_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_i = 3'b000;
        wb_hold_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_i = 3'b000; wb_hold_i = 1'b0;
        rd0_i = '0; rd1_i = '0; rd2_i = '0;
        data0_i = '0; data1_i = '0; data2_i = '0;
        tick();
        tick();

        // Reset state, and ready is masked while reset is high
        check("rst_wb", wb_o, 0);
        check("rst_wb_r", wb_r_o, 0);
        check("rst_result", result_o, 0);
        check("rst_qcount", qcount_o, 0);
        valid_i = 3'b111;
        #1;
        check("rst_ready", ready_o, 0);
        valid_i = 3'b000;
        reset = 1'b0;
        tick();

        // Single ALU result
        rd0_i = 4'd5; data0_i = 32'h1234_5678; valid_i = 3'b001;
        #1;
        check("single_ready", ready_o, 3'b001);
        tick();
        valid_i = 3'b000;
        check("single_q1", qcount_o, 1);
        check("single_wb0", wb_o, 0);
        tick();
        check("single_wb", wb_o, 1);
        check("single_wb_r", wb_r_o, 5);
        check("single_result", result_o, 32'h1234_5678);
        check("single_q0", qcount_o, 0);
        tick();
        check("single_wb_off", wb_o, 0);

        // Fairness: all three valid for six grants
        do_reset();
        rd0_i = 4'd1; rd1_i = 4'd2; rd2_i = 4'd3;
        data0_i = 32'hA; data1_i = 32'hB; data2_i = 32'hC;
        valid_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_ready", ready_o, 64'(3'b001 << (i % 3)));
            tick();
            if (i >= 1) begin
                check("rr_wb", wb_o, 1);
                check("rr_wb_r", wb_r_o, 64'((i - 1) % 3 + 1));
            end
        end
        valid_i = 3'b000;
        tick();
        check("rr_last_wb_r", wb_r_o, 3);
        check("rr_last_result", result_o, 32'hC);
        tick();
        check("rr_idle_wb", wb_o, 0);
        check("rr_idle_q", qcount_o, 0);

        // Fill under hold with MUL entries 1..6
        do_reset();
        wb_hold_i = 1'b1;
        valid_i = 3'b010;
        for (int n = 1; n <= 4; n++) begin
            rd1_i = 4'(n); data1_i = 32'(n * 16);
            #1;
            check("fill_ready", ready_o, 3'b010);
            tick();
            check("fill_q", qcount_o, 64'(n));
            check("fill_wb", wb_o, 0);
        end
        rd1_i = 4'd5; data1_i = 32'd80;
        for (int n = 0; n < 2; n++) begin
            #1;
            check("full_ready", ready_o, 3'b000);
            tick();
            check("full_wb", wb_o, 0);
            check("full_q", qcount_o, 4);
        end
        wb_hold_i = 1'b0;
        #1;
        check("release_ready", ready_o, 3'b010);
        tick();
        check("release_wb_r1", wb_r_o, 1);
        check("release_q", qcount_o, 4);
        rd1_i = 4'd6; data1_i = 32'd96;
        #1;
        check("release_ready6", ready_o, 3'b010);
        tick();
        valid_i = 3'b000;
        check("release_wb_r2", wb_r_o, 2);
        check("release_q2", qcount_o, 4);
        for (int n = 3; n <= 6; n++) begin
            tick();
            check("drain_wb", wb_o, 1);
            check("drain_wb_r", wb_r_o, 64'(n));
            check("drain_result", result_o, 64'(n * 16));
            check("drain_q", qcount_o, 64'(6 - n));
        end
        tick();
        check("drain_done", wb_o, 0);

        // Full with simultaneous LSU push and pop
        do_reset();
        wb_hold_i = 1'b1;
        valid_i = 3'b001;
        for (int n = 8; n <= 11; n++) begin
            rd0_i = 4'(n); data0_i = 32'(n);
            tick();
        end
        valid_i = 3'b100;
        rd2_i = 4'd12; data2_i = 32'd12;
        check("pp_full_q", qcount_o, 4);
        #1;
        check("pp_ready_hold", ready_o, 3'b000);
        wb_hold_i = 1'b0;
        #1;
        check("pp_ready_lsu", ready_o, 3'b100);
        tick();
        valid_i = 3'b000;
        check("pp_q", qcount_o, 4);
        check("pp_wb", wb_o, 1);
        check("pp_wb_r", wb_r_o, 8);
        for (int n = 9; n <= 12; n++) begin
            tick();
            check("pp_drain_wb_r", wb_r_o, 64'(n));
        end

        // Reset with entries queued discards them
        do_reset();
        wb_hold_i = 1'b1;
        valid_i = 3'b001;
        for (int n = 13; n <= 15; n++) begin
            rd0_i = 4'(n);
            tick();
        end
        valid_i = 3'b000;
        check("mid_q3", qcount_o, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb_hold_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("mid_wb", wb_o, 0);
            check("mid_q", qcount_o, 0);
        end
        valid_i = 3'b111;
        #1;
        check("mid_grant_alu", ready_o, 3'b001);
        valid_i = 3'b000;

        // Outputs hold on idle
        do_reset();
        rd0_i = 4'd7; data0_i = 32'hDEAD_BEEF; valid_i = 3'b001;
        tick();
        valid_i = 3'b000;
        tick();
        check("idle_wb", wb_o, 1);
        check("idle_wb_r", wb_r_o, 7);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("idle_hold_wb", wb_o, 0);
            check("idle_hold_wb_r", wb_r_o, 7);
            check("idle_hold_result", result_o, 32'hDEAD_BEEF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
